vga_layer_mixer: RTL and testbench
==================================

VGA_LAYER_MIXER -- requirements
Module: vga_layer_mixer

Interface
REQ-001 Parameter NUM_LAYERS, default 2, number of overlay layers (1..4).
REQ-002 Parameter LAYER_W, default 64, layer width in pixels (power of two, 8..256).
REQ-003 Parameter LAYER_H, default 64, layer height in pixels (power of two, 8..256).
REQ-004 Parameter KEY_RGB, default 12'hF0F, transparent colour key.
REQ-005 Derived: AW = log2(LAYER_W) + log2(LAYER_H), ROM address width per layer.
REQ-006 pclk  in  1  pixel clock; all logic on rising edge.
REQ-007 rst_n  in  1  synchronous active-low reset.
REQ-008 hcount_in, vcount_in  in  11 each  pixel counters from upstream stage.
REQ-009 hsync_in, vsync_in, hblnk_in, vblnk_in  in  1 each  upstream timing.
REQ-010 rgb_in  in  12  upstream pixel, {b,g,r} 4 bits each.
REQ-011 layer_x, layer_y  in  NUM_LAYERS*12 each  top-left position per layer, layer i in bits [12i+11:12i].
REQ-012 layer_en  in  NUM_LAYERS  per-layer enable.
REQ-013 key_en  in  NUM_LAYERS  per-layer colour-key transparency enable.
REQ-014 rom_addr  out  NUM_LAYERS*AW  per-layer image ROM address.
REQ-015 rom_data  in  NUM_LAYERS*12  per-layer ROM data, valid one pclk after rom_addr.
REQ-016 hcount_out, vcount_out  out  11 each  counters delayed to match rgb_out.
REQ-017 hsync_out, vsync_out, hblnk_out, vblnk_out  out  1 each  delayed timing.
REQ-018 rgb_out  out  12  mixed pixel.
REQ-019 hit_valid  out  1  an opaque layer pixel won at this output pixel.
REQ-020 hit_id  out  2  index of winning layer; 0 when hit_valid low.

Function
REQ-021 Latency: every output SHALL reflect the input sampled 3 pclk edges earlier; all sideband signals delayed identically.
REQ-022 Shadow regs for layer_x, layer_y, layer_en, key_en SHALL load only on the pclk edge where vsync_in is 1 and was 0 on the previous edge; mid-frame changes take effect next frame.
REQ-023 Stage 1 (edge 1): per layer, in_win = en & (hcount >= x) & (hcount < x+LAYER_W) & (vcount >= y) & (vcount < y+LAYER_H); sums computed 13 bits wide, no wrap.
REQ-024 Stage 1 rom_addr_i = {(vcount-y)[log2 LAYER_H-1:0], (hcount-x)[log2 LAYER_W-1:0]} when in_win, else 0; registered.
REQ-025 Stage 2 (edge 2): register in_win flags, rgb_in and sideband; ROM data consumed combinationally after edge 2.
REQ-026 opaque_i = in_win_i & ~(key_en_i & rom_data_i == KEY_RGB).
REQ-027 Priority: highest-index opaque layer wins; rgb_out = its rom_data, hit_valid=1, hit_id=index.
REQ-028 No opaque layer: rgb_out = delayed rgb_in, hit_valid=0, hit_id=0.
REQ-029 Blanking: if delayed hblnk or vblnk is 1, rgb_out=0, hit_valid=0, hit_id=0 regardless of layers.
REQ-030 Layers partly off-screen SHALL be clipped naturally; x or y >= 2048-LAYER dims never hits invalid pixels.
REQ-031 Layers with layer_en=0 SHALL never hit and drive rom_addr 0.

Reset
REQ-032 While rst_n=0 at an edge: all pipeline regs, shadow regs and outputs SHALL clear to 0 (rgb_out 0, syncs 0, blanks 0, counters 0, hit 0).
REQ-033 Reset asserted mid-frame SHALL flush the pipeline; first valid output 3 edges after rst_n returns high; shadows stay 0 (layers off) until the next vsync rising edge.

Verification
REQ-034 Pass-through: NUM_LAYERS=2, layer_en=0, rgb_in=12'h123 visible -> rgb_out=12'h123 exactly 3 edges later, hit_valid=0, syncs delayed 3.
REQ-035 Priority: layers 0,1 both at (100,100), ROM0=12'h00F, ROM1=12'hF00, pixel (110,110) -> rgb_out=12'hF00, hit_id=1; ROM1=KEY_RGB with key_en[1]=1 -> 12'h00F, hit_id=0.
REQ-036 Window edges: layer 0 at x=200, LAYER_W=64 -> hcount 199 miss, 200 hit addr dx=0, 263 hit dx=63, 264 miss; same on vertical.
REQ-037 Frame coherence: change layer_x mid-frame -> old position used until vsync_in rising edge, new position from following frame.
REQ-038 Blanking and reset: layer covering hblnk region -> rgb_out=0 there; rst_n low 1 cycle mid-line -> all outputs 0, pass-through resumes after 3 edges, layers hidden until next vsync.

Source files
------------

// File: rtl/vga_layer_mixer.sv
// Overlays up to four positioned, colour-keyed image layers onto a VGA pixel stream.
// The pipeline is three stages deep, and every sideband signal is delayed to match rgb_out.
module vga_layer_mixer #(
   parameter int          NUM_LAYERS = 2,
   parameter int          LAYER_W    = 64,
   parameter int          LAYER_H    = 64,
   parameter logic [11:0] KEY_RGB    = 12'hF0F,
   localparam int         XW         = $clog2(LAYER_W),
   localparam int         YW         = $clog2(LAYER_H),
   localparam int         AW         = XW + YW
) (
   input  logic                       pclk,
   input  logic                       rst_n,
   input  logic [10:0]                hcount_in,
   input  logic [10:0]                vcount_in,
   input  logic                       hsync_in,
   input  logic                       vsync_in,
   input  logic                       hblnk_in,
   input  logic                       vblnk_in,
   input  logic [11:0]                rgb_in,
   input  logic [NUM_LAYERS*12-1:0]   layer_x,
   input  logic [NUM_LAYERS*12-1:0]   layer_y,
   input  logic [NUM_LAYERS-1:0]      layer_en,
   input  logic [NUM_LAYERS-1:0]      key_en,
   output logic [NUM_LAYERS*AW-1:0]   rom_addr,
   input  logic [NUM_LAYERS*12-1:0]   rom_data,
   output logic [10:0]                hcount_out,
   output logic [10:0]                vcount_out,
   output logic                       hsync_out,
   output logic                       vsync_out,
   output logic                       hblnk_out,
   output logic                       vblnk_out,
   output logic [11:0]                rgb_out,
   output logic                       hit_valid,
   output logic [1:0]                 hit_id
);

   // Widen to 13 bits so that x + LAYER_W cannot wrap for positions near 4095.
   function automatic logic in_window(input logic [10:0] hc, input logic [10:0] vc,
                                      input logic [11:0] x, input logic [11:0] y);
      logic [12:0] h13, v13, x13, y13;
      h13 = {2'b00, hc};
      v13 = {2'b00, vc};
      x13 = {1'b0, x};
      y13 = {1'b0, y};
      return (h13 >= x13) && (h13 < x13 + 13'(LAYER_W)) &&
             (v13 >= y13) && (v13 < y13 + 13'(LAYER_H));
   endfunction

   function automatic logic [AW-1:0] win_addr(input logic [10:0] hc, input logic [10:0] vc,
                                              input logic [11:0] x, input logic [11:0] y);
      logic [XW-1:0] dx;
      logic [YW-1:0] dy;
      dx = XW'({1'b0, hc} - x);
      dy = YW'({1'b0, vc} - y);
      return {dy, dx};
   endfunction

   logic                     vsync_prev_q, vsync_prev_d;
   logic                     vs_rise;
   logic [NUM_LAYERS*12-1:0] x_sh_q, x_sh_d, y_sh_q, y_sh_d;
   logic [NUM_LAYERS-1:0]    en_sh_q, en_sh_d, key_sh_q, key_sh_d;

   logic                     vld_p1_q, vld_p1_d;
   logic [10:0]              hcount_p1_q, hcount_p1_d, vcount_p1_q, vcount_p1_d;
   logic [3:0]               sync_p1_q, sync_p1_d;
   logic [11:0]              rgb_p1_q, rgb_p1_d;
   logic [NUM_LAYERS-1:0]    in_win_p1_q, in_win_p1_d, key_p1_q, key_p1_d;
   logic [NUM_LAYERS*AW-1:0] rom_addr_q, rom_addr_d;

   logic                     vld_p2_q, vld_p2_d;
   logic [10:0]              hcount_p2_q, hcount_p2_d, vcount_p2_q, vcount_p2_d;
   logic [3:0]               sync_p2_q, sync_p2_d;
   logic [11:0]              rgb_p2_q, rgb_p2_d;
   logic [NUM_LAYERS-1:0]    in_win_p2_q, in_win_p2_d, key_p2_q, key_p2_d;

   logic [10:0]              hcount_out_q, hcount_out_d, vcount_out_q, vcount_out_d;
   logic [3:0]               sync_out_q, sync_out_d;
   logic [11:0]              rgb_out_q, rgb_out_d;
   logic                     hit_valid_q, hit_valid_d;
   logic [1:0]               hit_id_q, hit_id_d;

   always_comb begin
      // Layer configuration is sampled once per frame, on the vsync rising edge.
      vs_rise      = vsync_in & ~vsync_prev_q;
      vsync_prev_d = vsync_in;
      x_sh_d       = vs_rise ? layer_x  : x_sh_q;
      y_sh_d       = vs_rise ? layer_y  : y_sh_q;
      en_sh_d      = vs_rise ? layer_en : en_sh_q;
      key_sh_d     = vs_rise ? key_en   : key_sh_q;

      // Stage 1: window test and ROM addressing
      vld_p1_d    = 1'b1;
      hcount_p1_d = hcount_in;
      vcount_p1_d = vcount_in;
      sync_p1_d   = {hsync_in, vsync_in, hblnk_in, vblnk_in};
      rgb_p1_d    = rgb_in;
      key_p1_d    = key_sh_q;
      in_win_p1_d = '0;
      rom_addr_d  = '0;
      for (int i = 0; i < NUM_LAYERS; i++) begin
         in_win_p1_d[i] = en_sh_q[i] &
                          in_window(hcount_in, vcount_in, x_sh_q[12*i +: 12], y_sh_q[12*i +: 12]);
         if (in_win_p1_d[i])
            rom_addr_d[AW*i +: AW] = win_addr(hcount_in, vcount_in,
                                              x_sh_q[12*i +: 12], y_sh_q[12*i +: 12]);
      end

      // Stage 2: align with the synchronous ROM read
      vld_p2_d    = vld_p1_q;
      hcount_p2_d = hcount_p1_q;
      vcount_p2_d = vcount_p1_q;
      sync_p2_d   = sync_p1_q;
      rgb_p2_d    = rgb_p1_q;
      in_win_p2_d = in_win_p1_q;
      key_p2_d    = key_p1_q;

      // Stage 3: priority mix; ascending scan lets the highest opaque index win
      hcount_out_d = hcount_p2_q;
      vcount_out_d = vcount_p2_q;
      sync_out_d   = sync_p2_q;
      rgb_out_d    = rgb_p2_q;
      hit_valid_d  = 1'b0;
      hit_id_d     = 2'd0;
      for (int i = 0; i < NUM_LAYERS; i++) begin
         if (in_win_p2_q[i] && !(key_p2_q[i] && (rom_data[12*i +: 12] == KEY_RGB))) begin
            rgb_out_d   = rom_data[12*i +: 12];
            hit_valid_d = 1'b1;
            hit_id_d    = 2'(i);
         end
      end
      if (!vld_p2_q || sync_p2_q[1] || sync_p2_q[0]) begin
         rgb_out_d   = 12'h000;
         hit_valid_d = 1'b0;
         hit_id_d    = 2'd0;
      end
   end

   always_ff @(posedge pclk) begin
      if (!rst_n) begin
         vsync_prev_q <= 1'b0;
         x_sh_q       <= '0;
         y_sh_q       <= '0;
         en_sh_q      <= '0;
         key_sh_q     <= '0;
         vld_p1_q     <= 1'b0;
         hcount_p1_q  <= '0;
         vcount_p1_q  <= '0;
         sync_p1_q    <= '0;
         rgb_p1_q     <= '0;
         in_win_p1_q  <= '0;
         key_p1_q     <= '0;
         rom_addr_q   <= '0;
         vld_p2_q     <= 1'b0;
         hcount_p2_q  <= '0;
         vcount_p2_q  <= '0;
         sync_p2_q    <= '0;
         rgb_p2_q     <= '0;
         in_win_p2_q  <= '0;
         key_p2_q     <= '0;
         hcount_out_q <= '0;
         vcount_out_q <= '0;
         sync_out_q   <= '0;
         rgb_out_q    <= '0;
         hit_valid_q  <= 1'b0;
         hit_id_q     <= '0;
      end else begin
         vsync_prev_q <= vsync_prev_d;
         x_sh_q       <= x_sh_d;
         y_sh_q       <= y_sh_d;
         en_sh_q      <= en_sh_d;
         key_sh_q     <= key_sh_d;
         vld_p1_q     <= vld_p1_d;
         hcount_p1_q  <= hcount_p1_d;
         vcount_p1_q  <= vcount_p1_d;
         sync_p1_q    <= sync_p1_d;
         rgb_p1_q     <= rgb_p1_d;
         in_win_p1_q  <= in_win_p1_d;
         key_p1_q     <= key_p1_d;
         rom_addr_q   <= rom_addr_d;
         vld_p2_q     <= vld_p2_d;
         hcount_p2_q  <= hcount_p2_d;
         vcount_p2_q  <= vcount_p2_d;
         sync_p2_q    <= sync_p2_d;
         rgb_p2_q     <= rgb_p2_d;
         in_win_p2_q  <= in_win_p2_d;
         key_p2_q     <= key_p2_d;
         hcount_out_q <= hcount_out_d;
         vcount_out_q <= vcount_out_d;
         sync_out_q   <= sync_out_d;
         rgb_out_q    <= rgb_out_d;
         hit_valid_q  <= hit_valid_d;
         hit_id_q     <= hit_id_d;
      end
   end

   assign rom_addr   = rom_addr_q;
   assign hcount_out = hcount_out_q;
   assign vcount_out = vcount_out_q;
   assign hsync_out  = sync_out_q[3];
   assign vsync_out  = sync_out_q[2];
   assign hblnk_out  = sync_out_q[1];
   assign vblnk_out  = sync_out_q[0];
   assign rgb_out    = rgb_out_q;
   assign hit_valid  = hit_valid_q;
   assign hit_id     = hit_id_q;

endmodule

// File: tb/tb_vga_layer_mixer.sv
// Directed bench for vga_layer_mixer: a behavioural model fills a scoreboard queue with the
// expected result of each driven pixel, and the outputs are compared three clock edges later.
module tb_vga_layer_mixer;
   localparam int          NL  = 2;
   localparam int          AW  = 12;
   localparam logic [11:0] KEY = 12'hF0F;

   logic              pclk = 1'b0;
   logic              rst_n;
   logic [10:0]       hcount_in, vcount_in;
   logic              hsync_in, vsync_in, hblnk_in, vblnk_in;
   logic [11:0]       rgb_in;
   logic [NL*12-1:0]  layer_x, layer_y;
   logic [NL-1:0]     layer_en, key_en;
   logic [NL*AW-1:0]  rom_addr;
   logic [NL*12-1:0]  rom_data;
   logic [10:0]       hcount_out, vcount_out;
   logic              hsync_out, vsync_out, hblnk_out, vblnk_out;
   logic [11:0]       rgb_out;
   logic              hit_valid;
   logic [1:0]        hit_id;

   vga_layer_mixer #(.NUM_LAYERS(NL), .LAYER_W(64), .LAYER_H(64), .KEY_RGB(KEY)) dut (
      .pclk(pclk), .rst_n(rst_n),
      .hcount_in(hcount_in), .vcount_in(vcount_in),
      .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
      .rgb_in(rgb_in), .layer_x(layer_x), .layer_y(layer_y),
      .layer_en(layer_en), .key_en(key_en),
      .rom_addr(rom_addr), .rom_data(rom_data),
      .hcount_out(hcount_out), .vcount_out(vcount_out),
      .hsync_out(hsync_out), .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
      .rgb_out(rgb_out), .hit_valid(hit_valid), .hit_id(hit_id)
   );

   always #5 pclk = ~pclk;

   // Synchronous image ROMs: either a constant colour or the address itself ({dy,dx}).
   logic        rom_mode [NL];
   logic [11:0] rom_const [NL];
   logic        rom_mode_n [NL];
   logic [11:0] rom_const_n [NL];

   always @(posedge pclk) begin
      for (int i = 0; i < NL; i++)
         rom_data[12*i +: 12] <= rom_mode[i] ? rom_addr[AW*i +: 12] : rom_const[i];
   end

   typedef struct packed {
      logic [11:0] rgb;
      logic        hv;
      logic [1:0]  hid;
      logic [10:0] h;
      logic [10:0] v;
      logic [3:0]  sb;
   } exp_t;

   exp_t             q[$];
   int               n_cmp  = 0;
   int               n_fail = 0;
   logic [NL*12-1:0] sh_x, sh_y;
   logic [NL-1:0]    sh_en, sh_ken;
   logic             vs_prev;

   function automatic exp_t model(int h, int v, logic hs, logic vs, logic hb, logic vb,
                                  logic [11:0] rgb);
      exp_t e;
      int x, y;
      logic [11:0] d;
      e.rgb = rgb; e.hv = 1'b0; e.hid = 2'd0;
      e.h = 11'(h); e.v = 11'(v); e.sb = {hs, vs, hb, vb};
      for (int i = 0; i < NL; i++) begin
         x = int'(sh_x[12*i +: 12]);
         y = int'(sh_y[12*i +: 12]);
         if (sh_en[i] && h >= x && h < x + 64 && v >= y && v < y + 64) begin
            d = rom_mode[i] ? 12'(((v - y) << 6) | (h - x)) : rom_const[i];
            if (!(sh_ken[i] && d == KEY)) begin
               e.rgb = d; e.hv = 1'b1; e.hid = 2'(i);
            end
         end
      end
      if (hb || vb) begin
         e.rgb = 12'h000; e.hv = 1'b0; e.hid = 2'd0;
      end
      return e;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step(input int h, input int v, input logic hs, input logic vs,
                       input logic hb, input logic vb, input logic [11:0] rgb, input logic rst);
      exp_t e;
      exp_t z;
      @(negedge pclk);
      if (q.size() >= 3) begin
         e = q.pop_front();
         check("rgb_out", 32'(rgb_out), 32'(e.rgb));
         check("hit", 32'({hit_valid, hit_id}), 32'({e.hv, e.hid}));
         check("counters", 32'({hcount_out, vcount_out}), 32'({e.h, e.v}));
         check("sideband", 32'({hsync_out, vsync_out, hblnk_out, vblnk_out}), 32'(e.sb));
      end
      hcount_in = 11'(h); vcount_in = 11'(v);
      hsync_in = hs; vsync_in = vs; hblnk_in = hb; vblnk_in = vb;
      rgb_in = rgb; rst_n = rst;
      e = model(h, v, hs, vs, hb, vb, rgb);
      if (!rst) begin
         z = '0;
         foreach (q[k]) q[k] = z;
         e = z;
         sh_x = '0; sh_y = '0; sh_en = '0; sh_ken = '0; vs_prev = 1'b0;
      end else begin
         if (vs && !vs_prev) begin
            sh_x = layer_x; sh_y = layer_y; sh_en = layer_en; sh_ken = key_en;
         end
         vs_prev = vs;
      end
      q.push_back(e);
   endtask

   task automatic pix(input int h, input int v, input logic [11:0] rgb);
      step(h, v, 1'b0, 1'b0, 1'b0, 1'b0, rgb, 1'b1);
   endtask

   task automatic set_layer(input int i, input int x, input int y, input logic en, input logic ken);
      layer_x[12*i +: 12] = 12'(x);
      layer_y[12*i +: 12] = 12'(y);
      layer_en[i] = en;
      key_en[i]   = ken;
   endtask

   task automatic rom_next(input int i, input logic mode, input logic [11:0] c);
      rom_mode_n[i]  = mode;
      rom_const_n[i] = c;
   endtask

   // Blanked lines flush in-flight pixels before the ROM contents change, then vsync rises.
   task automatic new_frame();
      repeat (3) step(0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 12'hABC, 1'b1);
      for (int i = 0; i < NL; i++) begin
         rom_mode[i]  = rom_mode_n[i];
         rom_const[i] = rom_const_n[i];
      end
      step(0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 12'hABC, 1'b1);
      step(0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 12'hABC, 1'b1);
   endtask

   initial begin
      rst_n = 1'b0; hcount_in = '0; vcount_in = '0;
      hsync_in = 1'b0; vsync_in = 1'b0; hblnk_in = 1'b0; vblnk_in = 1'b0; rgb_in = '0;
      layer_x = '0; layer_y = '0; layer_en = '0; key_en = '0;
      sh_x = '0; sh_y = '0; sh_en = '0; sh_ken = '0; vs_prev = 1'b0;
      for (int i = 0; i < NL; i++) begin
         rom_mode[i] = 1'b0; rom_const[i] = '0; rom_mode_n[i] = 1'b0; rom_const_n[i] = '0;
      end

      repeat (4) step(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0);

      // Pass-through with layers disabled and varied sideband patterns
      step(10, 20, 1'b0, 1'b0, 1'b0, 1'b0, 12'h123, 1'b1);
      step(11, 20, 1'b1, 1'b0, 1'b0, 1'b0, 12'h123, 1'b1);
      step(12, 20, 1'b1, 1'b1, 1'b0, 1'b0, 12'h123, 1'b1);
      step(13, 20, 1'b0, 1'b1, 1'b1, 1'b0, 12'h123, 1'b1);
      step(14, 20, 1'b0, 1'b0, 1'b0, 1'b1, 12'h456, 1'b1);
      step(15, 21, 1'b0, 1'b0, 1'b0, 1'b0, 12'h123, 1'b1);

      // Two overlapping layers: layer 1 wins, then is keyed out
      set_layer(0, 100, 100, 1'b1, 1'b0);
      set_layer(1, 100, 100, 1'b1, 1'b0);
      rom_next(0, 1'b0, 12'h00F);
      rom_next(1, 1'b0, 12'hF00);
      new_frame();
      pix(110, 110, 12'h555);
      pix(99, 110, 12'h556);
      pix(100, 100, 12'h557);
      pix(163, 163, 12'h558);
      pix(164, 163, 12'h559);
      pix(163, 164, 12'h55A);
      set_layer(1, 100, 100, 1'b1, 1'b1);
      rom_next(1, 1'b0, KEY);
      new_frame();
      pix(110, 110, 12'h555);
      pix(120, 150, 12'h666);

      // Window edges with an address-echo ROM on layer 0
      set_layer(0, 200, 300, 1'b1, 1'b0);
      set_layer(1, 0, 0, 1'b0, 1'b0);
      rom_next(0, 1'b1, 12'h000);
      new_frame();
      pix(199, 310, 12'h101);
      pix(200, 310, 12'h102);
      pix(263, 310, 12'h103);
      pix(264, 310, 12'h104);
      pix(210, 299, 12'h105);
      pix(210, 300, 12'h106);
      pix(210, 363, 12'h107);
      pix(210, 364, 12'h108);

      // Mid-frame move takes effect only after the next vsync rising edge
      set_layer(0, 400, 300, 1'b1, 1'b0);
      pix(210, 310, 12'h201);
      pix(410, 310, 12'h202);
      new_frame();
      pix(210, 310, 12'h203);
      pix(410, 310, 12'h204);

      // Blanking over a covered pixel
      step(410, 310, 1'b1, 1'b0, 1'b1, 1'b0, 12'h777, 1'b1);
      step(411, 311, 1'b0, 1'b0, 1'b0, 1'b1, 12'h778, 1'b1);
      pix(412, 312, 12'h779);

      // Partly off-screen layer and a far-out position that must not wrap
      set_layer(0, 4090, 0, 1'b1, 1'b0);
      set_layer(1, 2000, 2020, 1'b1, 1'b0);
      rom_next(1, 1'b0, 12'h0F0);
      new_frame();
      pix(2047, 2047, 12'h301);
      pix(1999, 2047, 12'h302);
      pix(10, 10, 12'h303);
      pix(2000, 2019, 12'h304);
      pix(2000, 2020, 12'h305);

      // Reset mid-line: pipeline flushes, layers stay hidden until the next vsync
      pix(2040, 2040, 12'h401);
      pix(2041, 2040, 12'h402);
      step(2042, 2040, 1'b1, 1'b0, 1'b0, 1'b0, 12'h403, 1'b0);
      pix(2043, 2040, 12'h404);
      pix(2044, 2040, 12'h405);
      pix(2045, 2040, 12'h406);
      pix(2046, 2040, 12'h407);
      new_frame();
      pix(2046, 2040, 12'h408);

      repeat (3) step(0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h000, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
